// File: rtl/multu_pkg.sv
// Shared definitions for the iterative unsigned multiplier and its
// HI/LO consumers.
package multu_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

    typedef struct packed {
        logic [MUL_WIDTH-1:0] hi;
        logic [MUL_WIDTH-1:0] lo;
    } hilo_t;

endpackage

// File: rtl/multu.sv
// Radix-2 shift-add unsigned multiplier, one step per falling clock edge.
// Shares the divider's start/busy/done handshake.
module multu
    import multu_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic             start,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] mcand_r;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   sum;

    // The carry out of the add lands in hi_r's top bit after the shift.
    always_comb begin
        sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mcand_r} : '0);
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            hi_r    <= '0;
            lo_r    <= '0;
            mcand_r <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            mcand_r <= multiplicand;
            lo_r    <= multiplier;
            hi_r    <= '0;
            count   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else if (busy) begin
            hi_r  <= sum[WIDTH:1];
            lo_r  <= {sum[0], lo_r[WIDTH-1:1]};
            count <= count + 1'b1;
            if (count == LAST) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign hi = hi_r;
    assign lo = lo_r;

endmodule

// File: tb/tb_multu.sv
// Scoreboard bench for multu: stimulus pushes expected products, a
// monitor pops and compares on each done pulse.
module tb_multu;
    import multu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        start = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int n_push = 0;
    hilo_t exp_q[$];
    hilo_t last_exp;

    multu #(.WIDTH(32)) dut (
        .clock(clock),
        .reset(reset),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .start(start),
        .hi(hi),
        .lo(lo),
        .busy(busy),
        .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, req);
        end
    endtask

    // Monitor: DUT changes on the falling edge, sample on the rising edge.
    always @(posedge clock) begin
        if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", {hi, lo}, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                hilo_t e;
                e = exp_q.pop_front();
                check("product", {hi, lo}, e);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input hilo_t e, input bit expect_result);
        @(posedge clock);
        multiplicand = a;
        multiplier = b;
        start = 1'b1;
        if (expect_result) begin
            exp_q.push_back(e);
            n_push++;
            last_exp = e;
        end
        @(posedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clock);
        end
        check(name, 64'(n), 64'd32);
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] p, input string name);
        issue(a, b, p, 1'b1);
        wait_idle(name);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        repeat (3) @(posedge clock);
        reset = 1'b0;
        @(posedge clock);
        check("reset_state", {hi, lo}, 64'd0);
        check("reset_flags", {62'd0, busy, done}, 64'd0);

        op(32'd3, 32'd5, 64'h0000_0000_0000_000F, "lat_3x5");
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "lat_max");
        op(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, "lat_msb");
        op(32'd0, 32'h1234_5678, 64'd0, "lat_zero");

        // Result holds through an idle gap, done stays low.
        repeat (6) @(posedge clock);
        check("hold", {hi, lo}, last_exp);
        check("hold_done", 64'(done), 64'd0);

        // Restart mid-operation: only the second product may complete.
        issue(32'd7, 32'd9, '0, 1'b0);
        repeat (9) @(posedge clock);
        issue(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1);
        wait_idle("lat_restart");

        // Reset mid-operation aborts without a done pulse.
        issue(32'hDEAD_BEEF, 32'h0000_1234, '0, 1'b0);
        repeat (4) @(posedge clock);
        reset = 1'b1;
        @(posedge clock);
        reset = 1'b0;
        check("abort_flags", {62'd0, busy, done}, 64'd0);
        check("abort_prod", {hi, lo}, 64'd0);
        repeat (40) @(posedge clock);
        check("abort_idle", 64'(busy), 64'd0);

        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            op(ra, rb, 64'(ra) * 64'(rb), "lat_rand");
            if (i % 50 == 0) begin
                repeat (3) @(posedge clock);
                check("rand_hold", {hi, lo}, last_exp);
            end
        end

        repeat (3) @(posedge clock);
        check("done_count", 64'(n_done), 64'(n_push));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
